// File: rtl/uart_tx_ctrl_pkg.sv
// Shared types and constants for the UART transmit path (and the future RX side).
package uart_tx_ctrl_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_BAUD_W = 16;

  // Encoding of the CTRL parity-select bit
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } tx_state_t;

endpackage

// File: rtl/uart_tx_ctrl_baud_gen.sv
// Bit-period timer: counts 0..div-1 and flags the last clock of each bit.
// div must be >= 1; the caller clamps a programmed 0 to 1.
module uart_baud_gen
  import uart_tx_ctrl_pkg::*;
#(
  parameter int W = UART_BAUD_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] div,
  output logic         bit_done
);

  logic [W-1:0] cnt_q, cnt_d;

  assign bit_done = (cnt_q == div - W'(1));

  // Next count: wrap at the end of a bit or when the owner clears it
  always_comb begin
    // NOTE: assign a default first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clear || bit_done) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops bytes from the TX FIFO and shifts out
// start / 8 data (LSB first) / optional parity / 1 or 2 stop bits.
// Optional line-break generation is compiled in with UART_TX_BREAK_EN.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int BAUD_W = UART_BAUD_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              uart_en,
  input  logic              tx_en,
  input  logic              parity_enable,
  input  logic              parity,
  input  logic              stop_bit,
  input  logic [BAUD_W-1:0] baud_rate,
  input  logic              tx_fifo_empty,
  input  logic [DATA_W-1:0] tx_fifo_rdata,
`ifdef UART_TX_BREAK_EN
  input  logic              send_break,
`endif
  output logic              tx_fifo_rd_en,
  output logic              tx,
  output logic              busy
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_t         state_q;
  logic [DATA_W-1:0] shift_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic [BAUD_W-1:0] div_q;
  logic              par_en_q;
  logic              par_bit_q;
  logic              stop2_q;
  logic              tx_q;

  logic bit_done;
  logic bit_clear;
  logic pop_block;
  logic break_busy;
  logic idle_tx;

  // Bit timer only runs in the bit-carrying states; IDLE and LOAD hold it at 0
  // so every frame's first bit starts from a clean count.
  assign bit_clear = (state_q == IDLE) || (state_q == LOAD);

  uart_baud_gen #(.W(BAUD_W)) u_baud (
    .clock    (clock),
    .reset    (reset),
    .clear    (bit_clear),
    .div      (div_q),
    .bit_done (bit_done)
  );

`ifdef UART_TX_BREAK_EN
  logic brk_q;
  logic brk_hold_q;

  // Break state: brk_q mirrors send_break while idle; brk_hold_q keeps the
  // line high for one extra cycle after release before a pop is allowed.
  always_ff @(posedge clock) begin
    if (reset) begin
      brk_q      <= 1'b0;
      brk_hold_q <= 1'b0;
    end else begin
      brk_q      <= send_break && (state_q == IDLE);
      brk_hold_q <= brk_q;
    end
  end

  assign pop_block  = send_break | brk_q | brk_hold_q;
  assign break_busy = brk_q;
  assign idle_tx    = ~send_break;
`else
  assign pop_block  = 1'b0;
  assign break_busy = 1'b0;
  assign idle_tx    = 1'b1;
`endif

  // The pop strobe is issued in the IDLE cycle itself so the FIFO data is
  // valid during LOAD; reset masks it immediately.
  assign tx_fifo_rd_en = !reset && (state_q == IDLE) && uart_en && tx_en &&
                         !tx_fifo_empty && !pop_block;

  assign busy = !reset && ((state_q != IDLE) || tx_fifo_rd_en || break_busy);
  assign tx   = tx_q;

  // Frame sequencer with registered serial output
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      div_q     <= BAUD_W'(1);
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
    end else if ((state_q != IDLE) && !uart_en) begin
      // Global disable drops the frame on the spot; the popped byte is lost.
      state_q   <= IDLE;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          tx_q <= idle_tx;
          if (tx_fifo_rd_en) begin
            state_q <= LOAD;
            tx_q    <= 1'b1;
          end
        end
        LOAD: begin
          // Snapshot data and configuration so register writes cannot disturb
          // the frame in flight.
          shift_q   <= tx_fifo_rdata;
          div_q     <= (baud_rate == '0) ? BAUD_W'(1) : baud_rate;
          par_en_q  <= parity_enable;
          par_bit_q <= (parity == PARITY_ODD) ? ~^tx_fifo_rdata : ^tx_fifo_rdata;
          stop2_q   <= stop_bit;
          bit_idx_q <= '0;
          state_q   <= START;
          tx_q      <= 1'b0;
        end
        START: begin
          if (bit_done) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            shift_q <= shift_q >> 1;
            if (bit_idx_q == LAST_IDX) begin
              if (par_en_q) begin
                state_q <= PARITY;
                tx_q    <= par_bit_q;
              end else begin
                state_q <= STOP1;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
              tx_q      <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state_q <= STOP1;
            tx_q    <= 1'b1;
          end
        end
        STOP1: begin
          tx_q <= 1'b1;
          if (bit_done) begin
            state_q <= stop2_q ? STOP2 : IDLE;
          end
        end
        STOP2: begin
          tx_q <= 1'b1;
          if (bit_done) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule
